// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC mixer frequency scheduler.
//   WF            : frequency word width (signed, -Pi..Pi per clock)
//   CORDIC_STAGES : mixer pipeline depth
//   FLUSH_CYC     : blanking length after a retune (pipeline + NCO phase reg)
package cordic_pkg;
  localparam int WF            = 32;
  localparam int CORDIC_STAGES = 19;
  localparam int FLUSH_CYC     = CORDIC_STAGES + 1;

  typedef logic signed [WF-1:0] freq_word_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/cordic_freq_sched_if.sv
// Request bus from the command decoder into the frequency scheduler.
//   req_valid : per-requester update request
//   req_freq  : per-requester frequency word, slice i = [i*WF +: WF]
//   req_ready : one-hot grant back to the requesters
interface cordic_freq_sched_if #(
  parameter int NRX = 4,
  parameter int WF  = 32
);
  logic [NRX-1:0]    req_valid;
  logic [NRX*WF-1:0] req_freq;
  logic [NRX-1:0]    req_ready;

  modport master (output req_valid, output req_freq, input  req_ready);
  modport slave  (input  req_valid, input  req_freq, output req_ready);
endinterface

// File: rtl/cordic_freq_sched_rr_arbiter.sv
// Round-robin arbiter, NRX requesters, one-hot combinational grant.
//   clock, reset_n : clock / async active-low reset
//   req_valid      : request vector
//   grant          : one-hot grant (first requester at or after rr pointer)
// The pointer moves past the winner on every accepted grant. Since grant is
// only ever asserted on a valid requester, any grant is an accept.
module rr_arbiter
  import cordic_pkg::*;
#(
  parameter int NRX = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [NRX-1:0] req_valid,
  output logic [NRX-1:0] grant
);
  localparam int PW = (NRX > 1) ? $clog2(NRX) : 1;

  logic [PW-1:0] rr;
  logic [PW-1:0] gnt_idx;
  logic          found;
  arb_state_t    state;
  int            idx;

  always_comb begin
    state   = (|req_valid) ? ARB_GRANT : ARB_IDLE;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (state == ARB_GRANT) begin
      for (int k = 0; k < NRX; k++) begin
        idx = (int'(rr) + k) % NRX;
        if (!found && req_valid[PW'(idx)]) begin
          found             = 1'b1;
          grant[PW'(idx)]   = 1'b1;
          gnt_idx           = PW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  rr <= '0;
    else if (found) rr <= (int'(gnt_idx) == NRX - 1) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/cordic_freq_sched.sv
// Frequency-word scheduler between the command decoder and the mixer bank.
//   clock, reset_n : sample clock / async active-low reset
//   req            : request bus (slave side), one transfer per clock
//   rx_enable      : per-receiver enable
//   freq_out       : registered NCO frequency words, slice i = [i*WF +: WF]
//   rx_data_valid  : 1 = that mixer's output is settled
//   busy           : some receiver is still flushing
// Every retune (or enable rise) reloads the channel's flush counter so the
// mixer output is blanked until the CORDIC pipeline has drained.
module cordic_freq_sched #(
  parameter int NRX       = 4,
  parameter int WF        = cordic_pkg::WF,
  parameter int FLUSH_CYC = cordic_pkg::FLUSH_CYC
) (
  input  logic              clock,
  input  logic              reset_n,
  cordic_freq_sched_if.slave req,
  input  logic [NRX-1:0]    rx_enable,
  output logic [NRX*WF-1:0] freq_out,
  output logic [NRX-1:0]    rx_data_valid,
  output logic              busy
);
  localparam int CW = $clog2(FLUSH_CYC + 1);

  logic [NRX-1:0] grant;
  logic [NRX-1:0] cnt_nz;

  rr_arbiter #(.NRX(NRX)) u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req.req_valid),
    .grant     (grant)
  );

  assign req.req_ready = grant;

  for (genvar i = 0; i < NRX; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [WF-1:0] freq_q;
    logic          en_q;
    logic          vld_q;
    logic          reload;

    // Retune and enable rise share one reload; both at once is the same.
    assign reload    = grant[i] | (rx_enable[i] & ~en_q);
    assign cnt_nz[i] = (cnt != '0);

    // en_q resets high so a receiver enabled through reset does not see a
    // spurious rise and get blanked twice.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        freq_q <= '0;
        cnt    <= CW'(FLUSH_CYC);
        en_q   <= 1'b1;
        vld_q  <= 1'b0;
      end else begin
        en_q <= rx_enable[i];
        if (grant[i]) freq_q <= req.req_freq[i*WF +: WF];
        if (reload)      cnt <= CW'(FLUSH_CYC);
        else if (cnt_nz[i]) cnt <= cnt - 1'b1;
        vld_q <= rx_enable[i] & ~cnt_nz[i] & ~reload;
      end
    end

    assign freq_out[i*WF +: WF] = freq_q;
    assign rx_data_valid[i]     = vld_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy <= 1'b0;
    else          busy <= |cnt_nz;
  end
endmodule

// File: tb/tb_cordic_freq_sched.sv
// Directed bench for cordic_freq_sched. A reference model tracks, per
// channel, the edge index of the last reload; valid/busy follow from the
// distance to that edge. A negedge process compares every cycle; literal
// checks in the stimulus pin the model to hand-computed values.
module tb_cordic_freq_sched;
  import cordic_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int FC = 20;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   rx_enable;
  logic [N*W-1:0] freq_out;
  logic [N-1:0]   rx_data_valid;
  logic           busy;

  cordic_freq_sched_if #(.NRX(N), .WF(W)) rif ();

  cordic_freq_sched #(.NRX(N), .WF(W), .FLUSH_CYC(FC)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req           (rif.slave),
    .rx_enable     (rx_enable),
    .freq_out      (freq_out),
    .rx_data_valid (rx_data_valid),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Winner = first requester at or after the pointer, -1 when none.
  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  // ---------------- reference model ----------------
  int             n;
  int             last_load [N];
  int             rr_m;
  int             g_m;
  logic [N-1:0]   prev_en;
  logic [N-1:0]   exp_valid;
  logic [N*W-1:0] exp_freq;
  logic           exp_busy;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n         = 0;
      rr_m      = 0;
      prev_en   = '1;
      exp_valid = '0;
      exp_busy  = 1'b0;
      exp_freq  = '0;
      for (int c = 0; c < N; c++) last_load[c] = 0;
    end else begin
      n++;
      // busy reflects the counters as they stood before this edge
      exp_busy = 1'b0;
      for (int c = 0; c < N; c++)
        if (n - last_load[c] <= FC) exp_busy = 1'b1;
      g_m = pick(rif.req_valid, rr_m);
      if (g_m >= 0) begin
        exp_freq[g_m*W +: W] = rif.req_freq[g_m*W +: W];
        last_load[g_m] = n;
        rr_m = (g_m + 1) % N;
      end
      for (int c = 0; c < N; c++) begin
        if (rx_enable[c] && !prev_en[c]) last_load[c] = n;
        exp_valid[c] = rx_enable[c] && (n - last_load[c] > FC);
      end
      prev_en = rx_enable;
    end
  end

  // ---------------- per-cycle compare ----------------
  int p_chk;
  always @(negedge clock) begin
    p_chk = pick(rif.req_valid, rr_m);
    check("req_ready", rif.req_ready, (p_chk < 0) ? 128'd0 : (128'd1 << p_chk));
    check("freq_out", freq_out, exp_freq);
    check("rx_data_valid", rx_data_valid, exp_valid);
    check("busy", busy, exp_busy);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k);
    repeat (k) @(posedge clock);
    #2;
  endtask

  task automatic set_req(input int ch, input logic [W-1:0] f);
    rif.req_valid[ch]       = 1'b1;
    rif.req_freq[ch*W +: W] = f;
  endtask

  initial begin
    rif.req_valid = '0;
    rif.req_freq  = '0;
    rx_enable     = '1;
    reset_n       = 1'b0;
    #3;
    check("rst_freq", freq_out, 128'd0);
    check("rst_valid", rx_data_valid, 4'b0000);
    check("rst_busy", busy, 1'b0);
    @(posedge clock); #2;
    reset_n = 1'b1;

    // blank after reset release
    tick(20);
    check("blank_c20", rx_data_valid, 4'b0000);
    check("busy_c20", busy, 1'b1);
    tick(1);
    check("valid_c21", rx_data_valid, 4'b1111);
    check("freq_zero", freq_out, 128'd0);
    tick(2);

    // single request on ch2
    set_req(2, 32'h0CCC_CCCD);
    #1 check("ready_ch2", rif.req_ready, 4'b0100);
    tick(1);
    rif.req_valid = '0;
    check("freq2", freq_out[2*W +: W], 32'h0CCC_CCCD);
    check("ch2_low", rx_data_valid, 4'b1011);
    tick(20);
    check("ch2_low_T20", rx_data_valid, 4'b1011);
    tick(1);
    check("ch2_back_T21", rx_data_valid, 4'b1111);

    // one grant on ch3 moves the pointer back to 0
    set_req(3, 32'h1111_1111);
    tick(1);
    rif.req_valid = '0;

    // all four held: grants ch0..ch3 on consecutive clocks
    for (int g = 0; g < N; g++) set_req(g, 32'h0100_0000 + g);
    for (int g = 0; g < N; g++) begin
      #1 check($sformatf("rr_grant%0d", g), rif.req_ready, 4'b0001 << g);
      tick(1);
      rif.req_valid[g] = 1'b0;
    end
    tick(25);
    check("all_settled", rx_data_valid, 4'b1111);

    // ch1 retuned at T and T+10 (-Pi)
    set_req(1, 32'h2222_2222);
    tick(1);
    rif.req_valid = '0;
    tick(9);
    set_req(1, 32'h8000_0000);
    tick(1);
    rif.req_valid = '0;
    check("freq1_negpi", freq_out[1*W +: W], 32'h8000_0000);
    tick(20);
    check("ch1_low_T30", rx_data_valid[1], 1'b0);
    tick(1);
    check("ch1_back_T31", rx_data_valid[1], 1'b1);

    // rx_enable[3] dropped for 5 clocks
    tick(3);
    rx_enable[3] = 1'b0;
    tick(1);
    check("ch3_dis", rx_data_valid[3], 1'b0);
    tick(4);
    rx_enable[3] = 1'b1;
    tick(21);
    check("ch3_reblank", rx_data_valid[3], 1'b0);
    tick(1);
    check("ch3_back", rx_data_valid[3], 1'b1);
    check("freq3_kept", freq_out[3*W +: W], 32'h0100_0003);

    // reset while ch0 counter is at 7
    set_req(0, 32'h3333_3333);
    tick(1);
    rif.req_valid = '0;
    tick(13);
    #1 reset_n = 1'b0;
    #1;
    check("arst_freq", freq_out, 128'd0);
    check("arst_valid", rx_data_valid, 4'b0000);
    check("arst_busy", busy, 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(20);
    check("post_rst_c20", rx_data_valid, 4'b0000);
    tick(1);
    check("post_rst_c21", rx_data_valid, 4'b1111);
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
